// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the instruction/data memory bus arbiter.
// The optional timeout feature is enabled with MEM_ARB_TIMEOUT_EN.
package mem_bus_arbiter_pkg;

  // FSM states
  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_RESP = 2'd2;

  // Transaction owner
  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  // Default abort threshold, in cycles spent in ADDR or RESP
  localparam int TIMEOUT_DEFAULT = 255;

  // Width of the timeout counter
  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Two-way round-robin picker: a lone requester wins; on a tie, the side
// that did not own the previous transaction wins.
module mem_arb_rr_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
  input  logic last_owner,
  output logic any_req,
  output logic winner
);

  assign any_req = if_req | ls_req;
  assign winner  = (if_req & ls_req) ? ~last_owner
                 : (ls_req ? OWNER_LS : OWNER_IF);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the LSU.
// One outstanding transaction; responses are routed to the owner.
// Define MEM_ARB_TIMEOUT_EN to abort stalled ADDR/RESP phases after TIMEOUT cycles.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_err_o,

  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                ls_err_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_err_i,

  output logic                busy_o
);

  logic [1:0] state, state_nxt;
  logic       owner, last_owner;
  logic       any_req, winner;
  logic       in_addr, in_resp;
  logic       take;
  logic       timeout;

  mem_arb_rr_pick u_pick (
    .if_req     (if_req_i),
    .ls_req     (ls_req_i),
    .last_owner (last_owner),
    .any_req    (any_req),
    .winner     (winner)
  );

  assign in_addr = (state == ARB_ADDR);
  assign in_resp = (state == ARB_RESP);

  // A new command is captured from IDLE, or straight out of a completing
  // response so back-to-back transactions need no idle bubble.
  assign take = any_req & ((state == ARB_IDLE) | (in_resp & mem_rvalid_i));

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LIM = TO_CNT_W'(TIMEOUT);

  logic [TO_CNT_W-1:0] cnt;

  // A real handshake in the same cycle always beats the timeout.
  assign timeout = (cnt == TO_LIM) &
                   ((in_addr & ~mem_gnt_i) | (in_resp & ~mem_rvalid_i));

  // Cycle counter, restarted on every entry into ADDR or RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       cnt <= '0;
    else if (take | (in_addr & mem_gnt_i)) cnt <= '0;
    else if (in_addr | in_resp)       cnt <= cnt + 1'b1;
  end
`else
  // Counter compiled out: the FSM waits indefinitely. TIMEOUT is never
  // negative in a valid configuration, so this is a constant 0.
  assign timeout = (TIMEOUT < 0);
`endif

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (any_req) state_nxt = ARB_ADDR;
      ARB_ADDR: begin
        if (mem_gnt_i)    state_nxt = ARB_RESP;
        else if (timeout) state_nxt = ARB_IDLE;
      end
      ARB_RESP: begin
        if (mem_rvalid_i) state_nxt = any_req ? ARB_ADDR : ARB_IDLE;
        else if (timeout) state_nxt = ARB_IDLE;
      end
      default:            state_nxt = ARB_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Winner's command and ownership are latched on the pick cycle; fetches
  // are full-word reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner       <= OWNER_IF;
      last_owner  <= OWNER_IF;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (take) begin
      owner       <= winner;
      last_owner  <= winner;
      mem_we_o    <= (winner == OWNER_LS) ? ls_we_i    : 1'b0;
      mem_be_o    <= (winner == OWNER_LS) ? ls_be_i    : '1;
      mem_addr_o  <= (winner == OWNER_LS) ? ls_addr_i  : if_addr_i;
      mem_wdata_o <= (winner == OWNER_LS) ? ls_wdata_i : '0;
    end
  end

  // Request drops in the abort cycle so a late grant cannot start an
  // access the arbiter no longer tracks.
  assign mem_req_o = in_addr & ~timeout;
  assign busy_o    = (state != ARB_IDLE);

  // Response routing: only the owner ever sees gnt/rvalid/err.
  logic gnt, rvalid, err;
  assign gnt    = in_addr & (mem_gnt_i | timeout);
  assign rvalid = (in_resp & mem_rvalid_i) | timeout;
  assign err    = (in_resp & mem_rvalid_i & mem_err_i) | timeout;

  assign if_gnt_o    = gnt    & (owner == OWNER_IF);
  assign if_rvalid_o = rvalid & (owner == OWNER_IF);
  assign if_err_o    = err    & (owner == OWNER_IF);
  assign ls_gnt_o    = gnt    & (owner == OWNER_LS);
  assign ls_rvalid_o = rvalid & (owner == OWNER_LS);
  assign ls_err_o    = err    & (owner == OWNER_LS);

  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_i, if_gnt_o, if_rvalid_o, if_err_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i, ls_we_i, ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [BW-1:0] ls_be_i;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i, ls_rdata_o;
  logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          busy_o;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_be_i(ls_be_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .busy_o(busy_o)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_req_i = 0; if_addr_i = '0;
    ls_req_i = 0; ls_we_i = 0; ls_be_i = '0; ls_addr_i = '0; ls_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
  endtask

  task automatic pulse_reset();
    idle_in();
    reset = 0;
    tick();
    tick();
    reset = 1;
    tick();
  endtask

  // model / random-phase state
  bit            ir, lr, act, gd, own, last, mg, mv, me;
  logic [AW-1:0] ia, la, c_a;
  logic [DW-1:0] lwd, c_wd, md;
  logic          lwe, c_we;
  logic [BW-1:0] lbe, c_be;
  int            wait_n;
  bit            e_addr, e_done;

  initial begin
    // ---------------- reset state ----------------
    idle_in();
    reset = 0;
    #3;
    chk("rst_busy", busy_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_gnts", {if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, if_err_o, ls_err_o}, 0);
    tick();
    reset = 1;
    tick();

    // ---------------- single fetch, zero-wait ----------------
    if_req_i = 1; if_addr_i = 32'h100;
    #2 chk("f_c0_busy", busy_o, 0);
    tick();
    mem_gnt_i = 1;
    #2;
    chk("f_c1_req", mem_req_o, 1);
    chk("f_c1_addr", mem_addr_o, 32'h100);
    chk("f_c1_we_be", {mem_we_o, mem_be_o}, 5'h0F);
    chk("f_c1_gnt", {if_gnt_o, ls_gnt_o}, 2'b10);
    tick();
    if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h00500093;
    #2;
    chk("f_c2_rvalid", {if_rvalid_o, if_err_o}, 2'b10);
    chk("f_c2_rdata", if_rdata_o, 32'h00500093);
    chk("f_c2_ls_quiet", {ls_gnt_o, ls_rvalid_o, ls_err_o}, 0);
    chk("f_c2_req", mem_req_o, 0);
    tick();
    mem_rvalid_i = 0;
    #2 chk("f_c3_busy", busy_o, 0);

    // ---------------- contention: LS, IF, LS, IF ----------------
    if_req_i = 1; if_addr_i = 32'h200;
    ls_req_i = 1; ls_addr_i = 32'h300; ls_we_i = 0; ls_be_i = 4'hF;
    tick();
    for (int k = 0; k < 8; k++) begin
      bit exp_ls;
      exp_ls = ((k / 2) % 2) == 0;
      if (k == 5) ls_req_i = 0;
      if (k == 7) if_req_i = 0;
      mem_gnt_i = (k % 2) == 0;
      mem_rvalid_i = (k % 2) == 1;
      #2;
      chk("cont_mem_req", mem_req_o, (k % 2) == 0);
      chk("cont_busy", busy_o, 1);
      if ((k % 2) == 0) begin
        chk("cont_gnt", {ls_gnt_o, if_gnt_o}, exp_ls ? 2'b10 : 2'b01);
        chk("cont_addr", mem_addr_o, exp_ls ? 32'h300 : 32'h200);
      end else begin
        chk("cont_rvalid", {ls_rvalid_o, if_rvalid_o}, exp_ls ? 2'b10 : 2'b01);
      end
      tick();
    end
    mem_gnt_i = 0; mem_rvalid_i = 0;
    #2 chk("cont_end_busy", busy_o, 0);

    // ---------------- store with 3 wait cycles ----------------
    ls_req_i = 1; ls_we_i = 1; ls_be_i = 4'b0011; ls_addr_i = 32'h2000;
    ls_wdata_i = 32'hDEADBEEF;
    tick();
    for (int w = 0; w < 3; w++) begin
      #2;
      chk("st_req", mem_req_o, 1);
      chk("st_cmd", {mem_we_o, mem_be_o}, 5'b10011);
      chk("st_addr", mem_addr_o, 32'h2000);
      chk("st_wdata", mem_wdata_o, 32'hDEADBEEF);
      chk("st_no_gnt", ls_gnt_o, 0);
      tick();
    end
    mem_gnt_i = 1;
    #2 chk("st_gnt", {ls_gnt_o, if_gnt_o}, 2'b10);
    tick();
    ls_req_i = 0; ls_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_err_i = 0;
    #2 chk("st_resp", {ls_rvalid_o, ls_err_o, if_rvalid_o}, 3'b100);
    tick();
    mem_rvalid_i = 0;

    // ---------------- load with bus error ----------------
    ls_req_i = 1; ls_we_i = 0; ls_addr_i = 32'h40;
    tick();
    mem_gnt_i = 1;
    #2 chk("lderr_gnt", ls_gnt_o, 1);
    tick();
    ls_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_err_i = 1;
    #2 chk("lderr_resp", {ls_rvalid_o, ls_err_o, if_rvalid_o, if_err_o}, 4'b1100);
    tick();
    mem_rvalid_i = 0; mem_err_i = 0;

    // ---------------- reset during RESP ----------------
    if_req_i = 1; if_addr_i = 32'h80;
    tick();
    mem_gnt_i = 1;
    tick();
    if_req_i = 0; mem_gnt_i = 0;
    #2 chk("rr_busy_before", busy_o, 1);
    reset = 0;
    #1;
    chk("rr_busy", busy_o, 0);
    chk("rr_outs", {mem_req_o, if_gnt_o, if_rvalid_o, if_err_o, ls_gnt_o, ls_rvalid_o, ls_err_o}, 0);
    chk("rr_cmd", {mem_we_o, mem_be_o, mem_addr_o}, 0);
    tick();
    reset = 1;
    tick();
    mem_rvalid_i = 1;
    #2 chk("rr_late_rvalid", {if_rvalid_o, ls_rvalid_o, busy_o}, 0);
    tick();
    mem_rvalid_i = 0;

    // ---------------- fetch never granted ----------------
    if_req_i = 1; if_addr_i = 32'h400;
    tick();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 1; i <= TO; i++) begin
      #2 chk("to_wait", {if_gnt_o, if_rvalid_o, busy_o}, 3'b001);
      tick();
    end
    #2;
    chk("to_pulse", {if_gnt_o, if_rvalid_o, if_err_o}, 3'b111);
    chk("to_ls_quiet", {ls_gnt_o, ls_rvalid_o, ls_err_o}, 0);
    tick();
    if_req_i = 0;
    #2 chk("to_idle", busy_o, 0);
    tick();
`else
    for (int i = 1; i <= 12; i++) begin
      #2 chk("nto_wait", {if_gnt_o, if_rvalid_o, busy_o}, 3'b001);
      tick();
    end
    mem_gnt_i = 1;
    #2 chk("nto_gnt", if_gnt_o, 1);
    tick();
    if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    #2 chk("nto_rvalid", if_rvalid_o, 1);
    tick();
    mem_rvalid_i = 0;
`endif

    // ---------------- randomized run vs. model ----------------
    pulse_reset();
    ir = 0; lr = 0; act = 0; gd = 0; own = 0; last = 0; wait_n = 0;
    ia = '0; la = '0; lwd = '0; lwe = 0; lbe = '0;
    c_a = '0; c_wd = '0; c_we = 0; c_be = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!ir && $urandom_range(2) == 0) begin ir = 1; ia = $urandom; end
      if (!lr && $urandom_range(2) == 0) begin
        lr = 1; la = $urandom; lwe = 1'($urandom_range(1));
        lbe = 4'($urandom); lwd = $urandom;
      end
      e_addr = act && !gd;
      mg = e_addr && (wait_n >= 3 || $urandom_range(1) == 1);
      if (act) mv = gd && (wait_n >= 3 || $urandom_range(1) == 1);
      else     mv = ($urandom_range(7) == 0);
      me = ($urandom_range(3) == 0);
      md = $urandom;

      if_req_i = ir; if_addr_i = ia;
      ls_req_i = lr; ls_addr_i = la; ls_we_i = lwe; ls_be_i = lbe; ls_wdata_i = lwd;
      mem_gnt_i = mg; mem_rvalid_i = mv; mem_err_i = me; mem_rdata_i = md;
      #2;
      e_done = act && gd && mv;
      chk("rnd_busy", busy_o, act);
      chk("rnd_mem_req", mem_req_o, e_addr);
      if (e_addr) begin
        chk("rnd_addr", mem_addr_o, c_a);
        chk("rnd_we_be", {mem_we_o, mem_be_o}, {c_we, c_be});
        chk("rnd_wdata", mem_wdata_o, c_wd);
      end
      chk("rnd_gnt", {if_gnt_o, ls_gnt_o}, {e_addr && mg && !own, e_addr && mg && own});
      chk("rnd_rvalid", {if_rvalid_o, ls_rvalid_o}, {e_done && !own, e_done && own});
      chk("rnd_err", {if_err_o, ls_err_o}, {e_done && !own && me, e_done && own && me});
      chk("rnd_rdata", {if_rdata_o, ls_rdata_o}, {md, md});

      wait_n++;
      if (e_addr && mg) begin
        gd = 1; wait_n = 0;
        if (own) lr = 0; else ir = 0;
      end else if (!act || e_done) begin
        if (ir || lr) begin
          own = (ir && lr) ? !last : lr;
          last = own; act = 1; gd = 0; wait_n = 0;
          c_a  = own ? la : ia;
          c_we = own ? lwe : 1'b0;
          c_be = own ? lbe : 4'hF;
          c_wd = own ? lwd : '0;
        end else begin
          act = 0;
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port instruction/data memory bus between the instruction-fetch port and the load/store port of the core.
- Sits between instr_fetch / the LSU path and the external memory.
- Arbitrates two-way round-robin, holds one outstanding transaction at a time, and routes each response back to the requester that owns it.
- Sequences the memory port through a 3-state FSM with a req/gnt address phase and an rvalid response phase.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, cycles waited in ADDR or RESP before abort (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request; held stable until if_gnt_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch address phase accepted.
- if_rvalid_o  out  1  fetch response valid, one-cycle pulse.
- if_rdata_o  out  DATA_W  fetch read data.
- if_err_o  out  1  fetch bus error, valid with if_rvalid_o.
- ls_req_i  in  1  load/store request; held stable until ls_gnt_o.
- ls_we_i  in  1  1 = store.
- ls_be_i  in  DATA_W/8  byte enables.
- ls_addr_i  in  ADDR_W  load/store address.
- ls_wdata_i  in  DATA_W  store data.
- ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o  out  1/1/DATA_W/1  same meaning as the if_* outputs.
- mem_req_o  out  1  memory request.
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/DATA_W/8/ADDR_W/DATA_W  registered command.
- mem_gnt_i  in  1  memory accepted the command.
- mem_rvalid_i  in  1  memory response; sent for writes as well.
- mem_rdata_i  in  DATA_W  read data.
- mem_err_i  in  1  response error, qualified by mem_rvalid_i.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE; owner goes to IF; last_owner goes to IF, so the LSU wins the first tie.
  - All outputs are 0 and all command registers are cleared.
  - Any in-flight transaction is dropped; the memory is reset from the same source.
- IDLE:
  - If one requester is active, it is picked. If both are active, the one that is not last_owner is picked.
  - On the cycle it is picked, the winner's command is captured into the mem_* registers, owner and last_owner are set to the winner, and state goes to ADDR.
  - mem_rvalid_i seen in IDLE is ignored; this covers a stale response arriving after a timeout.
- ADDR:
  - mem_req_o=1.
  - owner's gnt_o = mem_gnt_i, combinational in the same cycle.
  - On mem_gnt_i, state goes to RESP.
  - The requester drops or changes its req only after gnt_o.
- RESP:
  - owner's rvalid_o = mem_rvalid_i; owner's err_o = mem_err_i & mem_rvalid_i.
  - Both rdata_o ports always equal mem_rdata_i; consumers qualify it with rvalid_o.
  - On mem_rvalid_i: if any request is pending, arbitrate and capture exactly as in IDLE and go straight to ADDR (back-to-back, no bubble). Otherwise go to IDLE.
- Non-owner gnt_o, rvalid_o and err_o are always 0.
- Latency: request to rvalid is a minimum of 3 cycles (capture, ADDR, RESP) against a zero-wait memory. Back-to-back throughput is one transaction per 2 cycles.
- Ties under sustained contention alternate strictly: LS, IF, LS, IF, ...
- A request arriving while busy waits; no queueing beyond the requester holding req.
- mem_gnt_i together with mem_rvalid_i in ADDR: the gnt is taken and the rvalid is ignored. The memory must not respond in the same cycle as it grants.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter is cleared on entering ADDR or RESP and increments each cycle in those states.
  - When the count reaches TIMEOUT without mem_gnt_i (ADDR) or mem_rvalid_i (RESP), the owner gets a one-cycle pulse of rvalid_o=1 and err_o=1. In ADDR it also gets gnt_o=1 in that cycle.
  - mem_req_o drops and state goes to IDLE.
- Not defined: no counter exists, and the FSM waits indefinitely in ADDR or RESP.

Decomposition:
- The shared defines header holds:
  - state encodings ARB_IDLE=2'd0, ARB_ADDR=2'd1, ARB_RESP=2'd2;
  - owner encodings OWNER_IF=1'b0, OWNER_LS=1'b1;
  - the default TIMEOUT value.
- One sub-module, mem_arb_rr_pick: combinational two-way round-robin picker.
  - Inputs: two req bits, last_owner.
  - Outputs: any_req, winner.
- FSM, command registers, response routing and the timeout counter stay in mem_bus_arbiter.

Test Plan:
- Single fetch, addr 0x100, memory with zero wait:
  - if_gnt_o in cycle 1, if_rvalid_o in cycle 2, if_rdata_o = mem data 0x00500093;
  - all ls_* outputs stay 0.
- if_req_i and ls_req_i asserted together out of reset, held for 4 transactions:
  - grant order is LS, IF, LS, IF;
  - no idle cycle between transactions (mem_req_o high every other cycle).
- Store ls_we_i=1, be=4'b0011, addr 0x2000, wdata 0xDEADBEEF, memory gnt after 3 wait cycles:
  - mem_* outputs hold those values for the 3 cycles;
  - ls_gnt_o coincides with mem_gnt_i;
  - ls_rvalid_o=1, ls_err_o=0.
- Load with mem_err_i=1 on rvalid: ls_err_o=1 in the rvalid cycle, if_err_o=0.
- reset pulled low in RESP, then released: all outputs 0 and busy_o=0 immediately; a late mem_rvalid_i after release produces no rvalid_o.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, memory never grants a fetch:
  - if_gnt_o, if_rvalid_o and if_err_o pulse together 8 cycles after ADDR entry;
  - FSM returns to IDLE.
  - Without the macro, busy_o stays 1.
